// File: rtl/fifo_flow_pkg.sv
// fifo_flow shared widths, depth helper and error bit indices.
package fifo_flow_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 4;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_flow_if.sv
// fifo_flow channel bundle: write/read handshake,
// thresholds, status and error flags.
interface fifo_flow_if
  import fifo_flow_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF
);

  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic                  err_clr;

  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  pause;
  logic                  err_overflow;
  logic                  err_underflow;

  modport master (
    output push, data_in, pop,
    output af_thresh, ae_thresh, err_clr,
    input  data_out, data_valid, count,
    input  empty, full, almost_full, almost_empty,
    input  pause, err_overflow, err_underflow
  );

  modport slave (
    input  push, data_in, pop,
    input  af_thresh, ae_thresh, err_clr,
    output data_out, data_valid, count,
    output empty, full, almost_full, almost_empty,
    output pause, err_overflow, err_underflow
  );

endinterface

// File: rtl/fifo_flow_ram.sv
// fifo_flow storage: sync write, async read, no reset.
module fifo_flow_ram #(
  parameter int DW = 6,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flow.sv
// fifo_flow: single-channel FIFO with thresholds,
// hysteretic pause and sticky error flags.
module fifo_flow
  import fifo_flow_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF
) (
  input logic        clk,
  input logic        reset_L,
  fifo_flow_if.slave bus
);

  typedef logic [ADDR_WIDTH:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(depth_of(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  cnt_t                  count_q;
  cnt_t                  count_next;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  pause_q;
  logic                  pause_next;
  logic [1:0]            err_q;
  logic [1:0]            err_set;
  logic [1:0]            err_next;
  logic                  empty;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign pop_ok  = bus.pop & ~empty;
  assign push_ok = bus.push & (~full | pop_ok);

  always_comb begin
    count_next = count_q;
    unique case (1'b1)
      push_ok & ~pop_ok: count_next = count_q + 1'b1;
      pop_ok & ~push_ok: count_next = count_q - 1'b1;
      default: ;
    endcase
  end

  // Illegal ae>=af collapses to a plain compare.
  always_comb begin
    pause_next = pause_q;
    if (count_next >= bus.af_thresh)
      pause_next = 1'b1;
    else if (bus.ae_thresh >= bus.af_thresh)
      pause_next = 1'b0;
    else if (count_next <= bus.ae_thresh)
      pause_next = 1'b0;
  end

  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = bus.push & ~push_ok;
    err_set[ERR_UNF] = bus.pop & ~pop_ok;
    err_next = (bus.err_clr ? 2'b00 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pause_q <= 1'b0;
      err_q   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= rd_data;
      end
      valid_q <= pop_ok;
      count_q <= count_next;
      pause_q <= pause_next;
      err_q   <= err_next;
    end
  end

  fifo_flow_ram #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (push_ok),
    .waddr(wr_ptr),
    .wdata(bus.data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  assign bus.data_out      = data_q;
  assign bus.data_valid    = valid_q;
  assign bus.count         = count_q;
  assign bus.empty         = empty;
  assign bus.full          = full;
  assign bus.almost_full   = (count_q >= bus.af_thresh);
  assign bus.almost_empty  = ~empty &
                             (count_q <= bus.ae_thresh);
  assign bus.pause         = pause_q;
  assign bus.err_overflow  = err_q[ERR_OVF];
  assign bus.err_underflow = err_q[ERR_UNF];

endmodule

// File: doc/fifo_flow.md
Name: fifo_flow

Overview:
Parametrised single-channel FIFO, successor to the fixed d0/d1 channel FIFOs. Adds programmable almost-full/almost-empty thresholds, a registered pause flag with hysteresis for upstream back-pressure, a valid strobe on read data, an occupancy output and sticky per-cause error flags with software clear. Instantiated once per channel between the demux and the arbiter stage.

Parameters:
DATA_WIDTH, 6, bits per entry
ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 16)

Ports:
clk  in  1  clock, all state on rising edge
reset_L  in  1  asynchronous active-low reset
push  in  1  write request
data_in  in  DATA_WIDTH  write data
pop  in  1  read request
af_thresh  in  ADDR_WIDTH+1  almost-full threshold (entries)
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold (entries)
err_clr  in  1  clears sticky error flags
data_out  out  DATA_WIDTH  read data, registered
data_valid  out  1  one-cycle strobe, data_out updated
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
almost_full  out  1  count>=af_thresh
almost_empty  out  1  count!=0 and count<=ae_thresh
pause  out  1  registered back-pressure with hysteresis
err_overflow  out  1  sticky: push rejected
err_underflow  out  1  sticky: pop rejected

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, data_out=0, data_valid=0, pause=0, err_*=0; hence empty=1, full=0, almost_*=0. Memory contents not cleared. Reset mid-operation discards all entries immediately.
- empty/full/almost_full/almost_empty are combinational from registered count and thresholds.
- push_ok = push & (!full | pop_ok); pop_ok = pop & !empty.
- Push at full with simultaneous pop: both accepted, count unchanged, pointers both advance.
- Pop at empty with simultaneous push: pop rejected (no bypass), push accepted, count 0->1, err_underflow set.
- Push at full without pop: data dropped, state unchanged, err_overflow set.
- Accepted push: mem[wr_ptr]<=data_in, wr_ptr+1 mod DEPTH (natural wrap).
- Accepted pop: data_out<=mem[rd_ptr] at that edge (1-cycle latency), data_valid=1 for that cycle only, rd_ptr+1 mod DEPTH. data_out holds value otherwise.
- count: +1 push only, -1 pop only, unchanged for both or neither; never exceeds DEPTH or underflows.
- pause next-state from count_next: set if count_next>=af_thresh; else clear if count_next<=ae_thresh; else hold. If ae_thresh>=af_thresh (illegal), pause = (count_next>=af_thresh), no hysteresis. af_thresh=0 forces pause=1 after first edge.
- Errors: set on the offending edge; err_clr clears both; new error in same cycle as err_clr wins (flag stays 1).
- Threshold inputs are quasi-static; changes take effect on next count evaluation, no glitch requirement on almost_* outputs.

Decomposition:
- Package fifo_flow_pkg: default widths, DEPTH derivation function, error-index constants (ERR_OVF=0, ERR_UNF=1).
- Sub-module fifo_flow_ram: simple dual-port array, sync write, async read at rd_ptr; no reset on storage. Control, counters, flags and pause live in fifo_flow.

Test Plan:
- Reset then 16 pushes of 0x01..0x10, no pop -> count 16, full=1, almost_full=1 at count>=af_thresh(12), empty=0, no errors.
- Pop 16 times from full -> data_out 0x01..0x10 in order, each one cycle after pop with data_valid=1; final empty=1, count=0.
- af=12, ae=4: fill to 12 -> pause rises at edge count becomes 12; drain to 5 -> pause stays 1; drain to 4 -> pause=0.
- Full, push+pop same cycle with 0x2A -> count stays 16, data_out=oldest entry, 0x2A later read last; no err_overflow. Empty, push+pop -> count 1, err_underflow=1.
- Push at full (no pop) -> err_overflow=1, count 16, entry dropped; err_clr pulse -> flag 0; err_clr coincident with new overflow -> flag stays 1.
- 40 interleaved push/pop with wrap past pointer 15->0 -> data order preserved; reset_L low mid-stream -> immediate count=0, empty=1, pause=0, data_valid=0.
